// File: rtl/bnn_image_loader.sv
// Producer side of the conv layer's image input: packs a host byte stream into IC binary
// planes, holds them under a level img_ready until the stage reports done, then rearms.
module bnn_image_loader #(
  parameter int IC       = 4,
  parameter int IMG_SIZE = 30,
  parameter int BYTE_W   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [BYTE_W-1:0]            in_data,
  output logic                         in_ready,
  input  logic                         layer_done,
  output logic                         img_ready,
  output logic [IMG_SIZE*IMG_SIZE-1:0] img_out [0:IC-1],
  output logic [15:0]                  frame_cnt,
  output logic                         busy
);
  localparam int PLANE      = IMG_SIZE * IMG_SIZE;
  localparam int TOTAL_BITS = IC * PLANE;
  localparam int NBYTES     = (TOTAL_BITS + BYTE_W - 1) / BYTE_W;
  localparam int IDX_W      = $clog2(NBYTES + 1);
  localparam int GW         = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {LOAD, HOLD, RELEASE} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TOTAL_BITS-1:0]   img_q, img_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    accept;
  int                      g;

  assign in_ready  = (state_q == LOAD);
  assign img_ready = (state_q == HOLD);
  assign busy      = (state_q != LOAD) || (idx_q != '0);
  assign frame_cnt = frame_cnt_q;
  assign accept    = in_valid && in_ready;

  // Planes are slices of one flat vector so bytes can straddle channel boundaries freely.
  for (genvar c = 0; c < IC; c++) begin : g_plane
    assign img_out[c] = img_q[c*PLANE +: PLANE];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    img_d       = img_q;
    frame_cnt_d = frame_cnt_q;
    g           = 0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          for (int b = 0; b < BYTE_W; b++) begin
            g = int'(idx_q) * BYTE_W + b;
            // Padding bits of the final byte fall past the last plane and are dropped.
            if (g < TOTAL_BITS) img_d[GW'(g)] = in_data[b];
          end
          if (idx_q == LAST) begin
            idx_d       = '0;
            state_d     = HOLD;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD:    if (layer_done) state_d = RELEASE;
      RELEASE: state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      img_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      img_q       <= img_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
endmodule

// File: tb/tb_bnn_image_loader.sv
// Directed bench for bnn_image_loader: default geometry plus a small 1x5x5 instance
// that exercises a partially used final byte.
module tb_bnn_image_loader;
  logic         clk = 0;
  logic         rst = 0;
  logic         in_valid = 0;
  logic [7:0]   in_data = '0;
  logic         in_ready;
  logic         layer_done = 0;
  logic         img_ready;
  logic [899:0] img_out [0:3];
  logic [15:0]  frame_cnt;
  logic         busy;

  logic         in_valid2 = 0;
  logic [7:0]   in_data2 = '0;
  logic         in_ready2;
  logic         layer_done2 = 0;
  logic         img_ready2;
  logic [24:0]  img_out2 [0:0];
  logic [15:0]  frame_cnt2;
  logic         busy2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bnn_image_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .layer_done(layer_done), .img_ready(img_ready), .img_out(img_out),
    .frame_cnt(frame_cnt), .busy(busy)
  );

  bnn_image_loader #(.IC(1), .IMG_SIZE(5), .BYTE_W(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .layer_done(layer_done2), .img_ready(img_ready2), .img_out(img_out2),
    .frame_cnt(frame_cnt2), .busy(busy2)
  );

  // Byte patterns: 0 = k mod 256, 1 = all ones, 2 = 7k+3 mod 256.
  function automatic logic [7:0] exp_byte(input int pat, input int k);
    case (pat)
      0:       return 8'(k % 256);
      1:       return 8'hFF;
      default: return 8'((k * 7 + 3) % 256);
    endcase
  endfunction

  function automatic logic [899:0] exp_plane(input int pat, input int c);
    logic [899:0] p;
    logic [7:0]   v;
    int           gi;
    p = '0;
    for (int i = 0; i < 900; i++) begin
      gi   = c * 900 + i;
      v    = exp_byte(pat, gi / 8);
      p[i] = v[gi % 8];
    end
    return p;
  endfunction

  task automatic send_byte(input logic [7:0] d);
    int n;
    in_valid = 1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready never rose");
    end
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic send_frame(input int pat, input bit gaps);
    for (int k = 0; k < 450; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(exp_byte(pat, k));
    end
  endtask

  task automatic release_frame();
    layer_done = 1;
    @(posedge clk); #1;
    layer_done = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    checks++;
    if (img_ready !== 1'b0) begin failures++; $display("FAIL reset_img_ready got=%b exp=0", img_ready); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (img_out[c] !== '0) begin failures++; $display("FAIL reset_plane%0d not zero", c); end
    end
  endtask

  task automatic test_full_frame();
    for (int k = 0; k < 449; k++) send_byte(exp_byte(0, k));
    checks++;
    if (img_ready !== 1'b0) begin failures++; $display("FAIL early_img_ready got=%b exp=0", img_ready); end
    send_byte(exp_byte(0, 449));
    checks++;
    if (img_ready !== 1'b1) begin failures++; $display("FAIL frame_img_ready got=%b exp=1", img_ready); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready got=%b exp=0", in_ready); end
    checks++;
    if (frame_cnt !== 16'd1) begin failures++; $display("FAIL frame_cnt1 got=%0d exp=1", frame_cnt); end
    checks++;
    if (img_out[0][7:0] !== 8'h00) begin failures++; $display("FAIL byte0 got=%h exp=00", img_out[0][7:0]); end
    checks++;
    if (img_out[0][15:8] !== 8'h01) begin failures++; $display("FAIL byte1 got=%h exp=01", img_out[0][15:8]); end
    checks++;
    if (img_out[0][899:896] !== 4'h0) begin failures++; $display("FAIL straddle_ch0 got=%h exp=0", img_out[0][899:896]); end
    checks++;
    if (img_out[1][3:0] !== 4'h7) begin failures++; $display("FAIL straddle_ch1 got=%h exp=7", img_out[1][3:0]); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (img_out[c] !== exp_plane(0, c)) begin failures++; $display("FAIL full_plane%0d content differs", c); end
    end
  endtask

  task automatic test_backpressure();
    int seen;
    release_frame();
    send_frame(0, 1'b1);
    checks++;
    if (frame_cnt !== 16'd2 || img_ready !== 1'b1) begin
      failures++; $display("FAIL bp_frame got cnt=%0d rdy=%b exp cnt=2 rdy=1", frame_cnt, img_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (img_out[c] !== exp_plane(0, c)) begin failures++; $display("FAIL bp_plane%0d content differs", c); end
    end
    in_valid = 1;
    in_data  = 8'hA5;
    seen = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0 || img_ready !== 1'b1) seen++;
    end
    in_valid = 0;
    checks++;
    if (seen != 0) begin failures++; $display("FAIL hold_stall bad_cycles=%0d exp=0", seen); end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (img_out[c] !== exp_plane(0, c)) begin failures++; $display("FAIL hold_plane%0d changed", c); end
    end
  endtask

  task automatic test_release();
    layer_done = 1;
    @(posedge clk); #1;
    layer_done = 0;
    checks++;
    if (img_ready !== 1'b0 || in_ready !== 1'b0) begin
      failures++; $display("FAIL release_cycle got rdy=%b in_rdy=%b exp 0 0", img_ready, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rearm got in_rdy=%b busy=%b exp 1 0", in_ready, busy);
    end
    layer_done = 1;
    @(posedge clk); #1;
    layer_done = 0;
    checks++;
    if (in_ready !== 1'b1 || img_ready !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL load_layer_done got in_rdy=%b rdy=%b busy=%b exp 1 0 0", in_ready, img_ready, busy);
    end
    send_frame(1, 1'b0);
    checks++;
    if (frame_cnt !== 16'd3 || img_ready !== 1'b1) begin
      failures++; $display("FAIL ones_frame got cnt=%0d rdy=%b exp cnt=3 rdy=1", frame_cnt, img_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (img_out[c] !== {900{1'b1}}) begin failures++; $display("FAIL ones_plane%0d not all ones", c); end
    end
  endtask

  task automatic test_reset_mid_load();
    release_frame();
    for (int k = 0; k < 200; k++) send_byte(exp_byte(2, k));
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL midload_busy got=%b exp=1", busy); end
    rst = 1; in_valid = 1; in_data = 8'h5A;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
      failures++; $display("FAIL midreset got in_rdy=%b busy=%b cnt=%0d exp 1 0 0", in_ready, busy, frame_cnt);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (img_out[c] !== '0) begin failures++; $display("FAIL midreset_plane%0d not zero", c); end
    end
    send_frame(2, 1'b0);
    checks++;
    if (frame_cnt !== 16'd1 || img_ready !== 1'b1) begin
      failures++; $display("FAIL fresh_frame got cnt=%0d rdy=%b exp cnt=1 rdy=1", frame_cnt, img_ready);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (img_out[c] !== exp_plane(2, c)) begin failures++; $display("FAIL fresh_plane%0d content differs", c); end
    end
  endtask

  task automatic test_partial();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin
        checks++;
        if (img_out2[0] !== 25'h0FFFFFF || img_ready2 !== 1'b0) begin
          failures++; $display("FAIL small_pre got=%h rdy=%b exp=0ffffff rdy=0", img_out2[0], img_ready2);
        end
      end
      checks++;
      if (in_ready2 !== 1'b1) begin failures++; $display("FAIL small_in_ready byte%0d got=0 exp=1", k); end
      in_valid2 = 1; in_data2 = 8'hFF;
      @(posedge clk); #1;
      in_valid2 = 0;
    end
    checks++;
    if (img_out2[0] !== 25'h1FFFFFF) begin failures++; $display("FAIL small_plane got=%h exp=1ffffff", img_out2[0]); end
    checks++;
    if (img_ready2 !== 1'b1 || frame_cnt2 !== 16'd1 || in_ready2 !== 1'b0) begin
      failures++; $display("FAIL small_done got rdy=%b cnt=%0d in_rdy=%b exp 1 1 0", img_ready2, frame_cnt2, in_ready2);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_release();
    test_reset_mid_load();
    test_partial();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
